// File: rtl/axi_ostd_tracker_pkg.sv
// Shared definitions for the outstanding-transaction tracker: default widths
// and the entry record stored per outstanding request.
package axi_ostd_tracker_pkg;

  localparam int IDW_DEF = 4;
  localparam int RW_DEF  = 2;
  localparam int DP_DEF  = 8;

  // Entry fields are sized for the widest supported configuration;
  // narrower instances zero-extend their ID and route into them.
  localparam int IDW_MAX = 16;
  localparam int RW_MAX  = 8;

  typedef struct packed {
    logic [IDW_MAX-1:0] id;
    logic [RW_MAX-1:0]  route;
  } entry_t;

  function automatic entry_t make_entry(input logic [IDW_MAX-1:0] id,
                                        input logic [RW_MAX-1:0]  route);
    entry_t e;
    e.id    = id;
    e.route = route;
    return e;
  endfunction

endpackage

// File: rtl/axi_ostd_tracker_if.sv
// Bundle of the allocate and response-lookup signals of the tracker.
// Handshake: an allocation transfers on a cycle where i_alloc_valid and
// o_alloc_ready are both high; a response beat is accepted on a cycle where
// i_rsp_valid and i_rsp_ready are both high. o_alloc_ready never depends on
// i_alloc_valid, and a valid source holds its payload until accepted.
interface axi_ostd_tracker_if
  import axi_ostd_tracker_pkg::*;
#(
  parameter int IDW = IDW_DEF,
  parameter int RW  = RW_DEF,
  parameter int DP  = DP_DEF
) ();
  localparam int CW = $clog2(DP + 1);

  logic           i_alloc_valid;
  logic           o_alloc_ready;
  logic [IDW-1:0] i_alloc_id;
  logic [RW-1:0]  i_alloc_route;
  logic           i_rsp_valid;
  logic           i_rsp_ready;
  logic [IDW-1:0] i_rsp_id;
  logic           i_rsp_last;
  logic           o_rsp_hit;
  logic [RW-1:0]  o_rsp_route;
  logic           o_rsp_err;
  logic [CW-1:0]  o_count;
  logic           o_full;
  logic           o_empty;

  modport master (
    output i_alloc_valid, i_alloc_id, i_alloc_route,
    output i_rsp_valid, i_rsp_ready, i_rsp_id, i_rsp_last,
    input  o_alloc_ready, o_rsp_hit, o_rsp_route, o_rsp_err,
    input  o_count, o_full, o_empty
  );

  modport slave (
    input  i_alloc_valid, i_alloc_id, i_alloc_route,
    input  i_rsp_valid, i_rsp_ready, i_rsp_id, i_rsp_last,
    output o_alloc_ready, o_rsp_hit, o_rsp_route, o_rsp_err,
    output o_count, o_full, o_empty
  );
endinterface

// File: rtl/axi_prio_enc.sv
// Lowest-index-first priority encoder: one-hot of the first set request bit,
// its binary index, and whether any bit is set.
module axi_prio_enc #(
  parameter int DP = 8,
  parameter int IW = $clog2(DP)
) (
  input  logic [DP-1:0] req_i,
  output logic [DP-1:0] onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    for (int i = DP - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IW'(i);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/axi_ostd_tracker.sv
// Outstanding-transaction tracker. Keeps a compacted, age-ordered table of
// issued request IDs with their route tags (index 0 oldest), resolves each
// response beat to the oldest matching entry in the same cycle, and retires
// that entry on the last accepted beat.
module axi_ostd_tracker
  import axi_ostd_tracker_pkg::*;
#(
  parameter int IDW = IDW_DEF,
  parameter int RW  = RW_DEF,
  parameter int DP  = DP_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  axi_ostd_tracker_if.slave bus
);

  localparam int CW = $clog2(DP + 1);
  localparam int IW = $clog2(DP);

  entry_t         ent_q [DP];
  entry_t         ent_d [DP];
  logic [DP-1:0]  valid_q, valid_d;
  logic [CW-1:0]  count_q, count_d;
  logic           err_q, err_d;

  logic [IDW-1:0] rsp_id;
  logic [IDW-1:0] alloc_id;
  logic [RW-1:0]  alloc_route;
  logic [DP-1:0]  match;
  logic [DP-1:0]  first_oh;
  logic [IW-1:0]  first_idx;
  logic           any_match;
  logic [DP-1:0]  at_or_above;
  logic [RW_MAX-1:0] route_sel;
  logic           full;
  logic           rsp_hit;
  logic           rsp_acc;
  logic           do_alloc;
  logic           do_free;
  logic [CW-1:0]  wr_pos;

  assign rsp_id      = bus.i_rsp_id;
  assign alloc_id    = bus.i_alloc_id;
  assign alloc_route = bus.i_alloc_route;

  // Compare the response ID against every valid entry.
  always_comb begin
    match = '0;
    for (int i = 0; i < DP; i++) begin
      match[i] = valid_q[i] && (ent_q[i].id == IDW_MAX'(rsp_id));
    end
  end

  axi_prio_enc #(.DP(DP), .IW(IW)) u_prio (
    .req_i    (match),
    .onehot_o (first_oh),
    .idx_o    (first_idx),
    .any_o    (any_match)
  );

  assign full      = (count_q == CW'(DP));
  assign rsp_hit   = bus.i_rsp_valid && any_match;
  assign rsp_acc   = bus.i_rsp_valid && bus.i_rsp_ready;
  assign do_alloc  = bus.i_alloc_valid && !full;
  assign do_free   = rsp_acc && bus.i_rsp_last && rsp_hit;
  assign wr_pos    = do_free ? (count_q - CW'(1)) : count_q;
  assign route_sel = ent_q[first_idx].route;

  // Mark the matched slot and every slot above it; those shift down on a free.
  always_comb begin
    logic acc;
    acc         = 1'b0;
    at_or_above = '0;
    for (int i = 0; i < DP; i++) begin
      acc            = acc | first_oh[i];
      at_or_above[i] = acc;
    end
  end

  // Next table contents: shift out the freed entry, then append the new one.
  always_comb begin
    for (int i = 0; i < DP; i++) begin
      ent_d[i] = ent_q[i];
    end
    if (do_free) begin
      for (int i = 0; i < DP - 1; i++) begin
        if (at_or_above[i]) ent_d[i] = ent_q[i+1];
      end
    end
    for (int i = 0; i < DP; i++) begin
      if (do_alloc && (wr_pos == CW'(i))) begin
        ent_d[i] = make_entry(IDW_MAX'(alloc_id), RW_MAX'(alloc_route));
      end
    end
  end

  // Next occupancy, thermometer valid vector and miss-error flag.
  always_comb begin
    count_d = count_q;
    case ({do_alloc, do_free})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = '0;
    for (int i = 0; i < DP; i++) begin
      valid_d[i] = (CW'(i) < count_d);
    end
    err_d = rsp_acc && !rsp_hit;
  end

  // Control state with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry payload storage; contents are qualified by valid_q, so no reset.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DP; i++) begin
      ent_q[i] <= ent_d[i];
    end
  end

  assign bus.o_alloc_ready = !full;
  assign bus.o_rsp_hit     = rsp_hit;
  assign bus.o_rsp_route   = rsp_hit ? RW'(route_sel) : '0;
  assign bus.o_rsp_err     = err_q;
  assign bus.o_count       = count_q;
  assign bus.o_full        = full;
  assign bus.o_empty       = (count_q == '0);

endmodule

// File: tb/tb_axi_ostd_tracker.sv
// Testbench for axi_ostd_tracker: directed scenarios plus randomized traffic,
// checked against an age-ordered queue model of the outstanding table.
module tb_axi_ostd_tracker;
  import axi_ostd_tracker_pkg::*;

  localparam int IDW = 4;
  localparam int RW  = 2;
  localparam int DP  = 8;
  localparam int CW  = $clog2(DP + 1);
  localparam int EW  = IDW + RW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  axi_ostd_tracker_if #(.IDW(IDW), .RW(RW), .DP(DP)) bus ();

  axi_ostd_tracker #(.IDW(IDW), .RW(RW), .DP(DP)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];   // {id, route}, oldest first
  logic          exp_err;
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic logic [RW:0] exp_comb();
    if (bus.i_rsp_valid) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i][EW-1:RW] == bus.i_rsp_id) return {1'b1, exp_q[i][RW-1:0]};
      end
    end
    return '0;
  endfunction

  // {count, full, empty, alloc_ready, err}
  function automatic logic [CW+3:0] exp_state();
    int c;
    c = exp_q.size();
    return {CW'(c), (c == DP), (c == 0), (c != DP), exp_err};
  endfunction

  function automatic logic [RW:0] obs_comb();
    return {bus.o_rsp_hit, bus.o_rsp_route};
  endfunction

  function automatic logic [CW+3:0] obs_state();
    return {bus.o_count, bus.o_full, bus.o_empty, bus.o_alloc_ready, bus.o_rsp_err};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic av, input int aid, input int ar,
                       input logic rv, input logic rr, input int rid,
                       input logic rl, input logic r);
    bus.i_alloc_valid = av;
    bus.i_alloc_id    = IDW'(aid);
    bus.i_alloc_route = RW'(ar);
    bus.i_rsp_valid   = rv;
    bus.i_rsp_ready   = rr;
    bus.i_rsp_id      = IDW'(rid);
    bus.i_rsp_last    = rl;
    rst               = r;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Advance one clock and apply the table rules to the model.
  task automatic tick();
    logic hit, alloc, free, err;
    int   k;
    hit = 1'b0;
    k   = 0;
    if (bus.i_rsp_valid) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i][EW-1:RW] == bus.i_rsp_id) begin
          hit = 1'b1;
          k   = i;
        end
      end
    end
    alloc = bus.i_alloc_valid && (exp_q.size() < DP);
    free  = bus.i_rsp_valid && bus.i_rsp_ready && bus.i_rsp_last && hit;
    err   = bus.i_rsp_valid && bus.i_rsp_ready && !hit;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else begin
      if (free)  exp_q.delete(k);
      if (alloc) exp_q.push_back({bus.i_alloc_id, bus.i_alloc_route});
      exp_err = err;
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    tick();
    tick();
    idle();
  endtask

  task automatic alloc(input int id, input int route);
    drive(1'b1, id, route, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs_state() !== {CW'(0), 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got %b required %b", obs_state(), {CW'(0), 4'b0110});
    end
    drive(1'b0, 0, 0, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    n_checks++;
    if (obs_comb() !== '0) begin
      n_fail++;
      $display("FAIL reset_lookup: got %b required 0", obs_comb());
    end
  endtask

  task automatic test_basic();
    int ids[3]    = '{3, 5, 3};
    int routes[3] = '{1, 2, 0};
    do_reset();
    for (int i = 0; i < 3; i++) alloc(ids[i], routes[i]);
    idle();
    n_checks++;
    if (bus.o_count !== CW'(3) || obs_state() !== exp_state()) begin
      n_fail++;
      $display("FAIL basic_count: got %b required %b", obs_state(), exp_state());
    end
    drive(1'b0, 0, 0, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    n_checks++;
    if (obs_comb() !== {1'b1, 2'd1} || obs_comb() !== exp_comb()) begin
      n_fail++;
      $display("FAIL basic_hit: got %b required %b", obs_comb(), {1'b1, 2'd1});
    end
    tick();
    n_checks++;
    if (bus.o_count !== CW'(2) || obs_state() !== exp_state()) begin
      n_fail++;
      $display("FAIL basic_free: got %b required %b", obs_state(), exp_state());
    end
    drive(1'b0, 0, 0, 1'b1, 1'b0, 5, 1'b0, 1'b0);
    n_checks++;
    if (obs_comb() !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL basic_rest5: got %b required %b", obs_comb(), {1'b1, 2'd2});
    end
    drive(1'b0, 0, 0, 1'b1, 1'b0, 3, 1'b0, 1'b0);
    n_checks++;
    if (obs_comb() !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL basic_rest3: got %b required %b", obs_comb(), {1'b1, 2'd0});
    end
  endtask

  task automatic test_full();
    do_reset();
    // Slots 4..7 share ID 10 so their ordering is visible through lookup.
    for (int i = 0; i < DP; i++) alloc((i < 4) ? i : 10, i % 4);
    idle();
    n_checks++;
    if (obs_state() !== {CW'(8), 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL full_flags: got %b required %b", obs_state(), {CW'(8), 4'b1000});
    end
    drive(1'b1, 9, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    idle();
    n_checks++;
    if (obs_state() !== exp_state() || bus.o_count !== CW'(8)) begin
      n_fail++;
      $display("FAIL full_drop: got %b required %b", obs_state(), exp_state());
    end
    drive(1'b0, 0, 0, 1'b1, 1'b0, 9, 1'b0, 1'b0);
    n_checks++;
    if (obs_comb() !== '0) begin
      n_fail++;
      $display("FAIL full_drop_lookup: got %b required 0", obs_comb());
    end
    for (int r = 0; r < 3; r++) begin
      drive(1'b0, 0, 0, 1'b1, 1'b1, 10, 1'b1, 1'b0);
      n_checks++;
      if (obs_comb() !== {1'b1, RW'(r)} || obs_comb() !== exp_comb()) begin
        n_fail++;
        $display("FAIL full_shift_%0d: got %b required %b", r, obs_comb(), {1'b1, RW'(r)});
      end
      tick();
      idle();
      n_checks++;
      if (obs_state() !== exp_state() || bus.o_count !== CW'(7 - r)) begin
        n_fail++;
        $display("FAIL full_free_%0d: got %b required %b", r, obs_state(), exp_state());
      end
    end
  endtask

  task automatic test_simul();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(i + 1, i);
    drive(1'b1, 7, 3, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    n_checks++;
    if (obs_comb() !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL simul_hit: got %b required %b", obs_comb(), {1'b1, 2'd0});
    end
    tick();
    idle();
    n_checks++;
    if (bus.o_count !== CW'(4) || obs_state() !== exp_state()) begin
      n_fail++;
      $display("FAIL simul_count: got %b required %b", obs_state(), exp_state());
    end
    for (int i = 2; i <= 4; i++) begin
      drive(1'b0, 0, 0, 1'b1, 1'b1, i, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 0, 0, 1'b1, 1'b0, 7, 1'b0, 1'b0);
    n_checks++;
    if (obs_comb() !== {1'b1, 2'd3} || bus.o_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL simul_tail: got %b/%0d required %b/1", obs_comb(), bus.o_count, {1'b1, 2'd3});
    end
  endtask

  task automatic test_err();
    logic [CW-1:0] cnt;
    cnt = bus.o_count;
    drive(1'b0, 0, 0, 1'b1, 1'b1, 9, 1'b1, 1'b0);
    n_checks++;
    if (obs_comb() !== '0) begin
      n_fail++;
      $display("FAIL err_miss: got %b required 0", obs_comb());
    end
    tick();
    idle();
    n_checks++;
    if (bus.o_rsp_err !== 1'b1 || obs_state() !== exp_state() || bus.o_count !== cnt) begin
      n_fail++;
      $display("FAIL err_pulse: got %b required %b", obs_state(), exp_state());
    end
    tick();
    n_checks++;
    if (bus.o_rsp_err !== 1'b0 || obs_state() !== exp_state()) begin
      n_fail++;
      $display("FAIL err_one_cycle: got %b required %b", obs_state(), exp_state());
    end
  endtask

  task automatic test_multibeat();
    do_reset();
    alloc(5, 2);
    alloc(6, 1);
    for (int b = 0; b < 4; b++) begin
      // beats 0,1 non-last; beat 2 last but stalled; beat 3 last accepted
      drive(1'b0, 0, 0, 1'b1, (b != 2), 5, (b >= 2), 1'b0);
      n_checks++;
      if (obs_comb() !== {1'b1, 2'd2}) begin
        n_fail++;
        $display("FAIL mb_hit_%0d: got %b required %b", b, obs_comb(), {1'b1, 2'd2});
      end
      tick();
      n_checks++;
      if (obs_state() !== exp_state() || bus.o_count !== CW'((b == 3) ? 1 : 2) ||
          bus.o_rsp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL mb_count_%0d: got %b required %b", b, obs_state(), exp_state());
      end
    end
    drive(1'b0, 0, 0, 1'b1, 1'b0, 5, 1'b0, 1'b0);
    n_checks++;
    if (obs_comb() !== '0) begin
      n_fail++;
      $display("FAIL mb_gone: got %b required 0", obs_comb());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 2, 1, 1'b1, 1'b0, 2, 1'b1, 1'b0);
    n_checks++;
    if (obs_comb() !== '0) begin
      n_fail++;
      $display("FAIL b2b_no_bypass: got %b required 0", obs_comb());
    end
    tick();
    drive(1'b0, 0, 0, 1'b1, 1'b0, 2, 1'b1, 1'b0);
    n_checks++;
    if (obs_comb() !== {1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL b2b_next_hit: got %b required %b", obs_comb(), {1'b1, 2'd1});
    end
    alloc(4, 3);
    alloc(6, 0);
    drive(1'b1, 8, 2, 1'b1, 1'b1, 15, 1'b1, 1'b1);
    tick();
    idle();
    n_checks++;
    if (obs_state() !== {CW'(0), 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_mid_reset: got %b required %b", obs_state(), {CW'(0), 4'b0110});
    end
    tick();
    n_checks++;
    if (obs_state() !== exp_state() || bus.o_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_reset_noerr: got %b required %b", obs_state(), exp_state());
    end
  endtask

  task automatic test_random();
    logic av, rv, rr, rl, r;
    int   aid, ar, rid;
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 63) == 0);
      av  = ($urandom_range(0, 2) != 0);
      aid = $urandom_range(0, 3);
      ar  = $urandom_range(0, 3);
      rv  = ($urandom_range(0, 1) == 1);
      rr  = ($urandom_range(0, 3) != 0);
      rl  = ($urandom_range(0, 1) == 1);
      if (exp_q.size() > 0 && $urandom_range(0, 3) != 0)
        rid = int'(exp_q[$urandom_range(0, exp_q.size() - 1)][EW-1:RW]);
      else
        rid = $urandom_range(0, 5);
      drive(av, aid, ar, rv, rr, rid, rl, r);
      n_checks++;
      if (obs_comb() !== exp_comb()) begin
        n_fail++;
        $display("FAIL rand_lookup@%0d: got %b required %b", n, obs_comb(), exp_comb());
      end
      tick();
      n_checks++;
      if (obs_state() !== exp_state()) begin
        n_fail++;
        $display("FAIL rand_state@%0d: got %b required %b", n, obs_state(), exp_state());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    exp_err = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_simul();
    test_err();
    test_multibeat();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_ostd_tracker.md
AXI_OSTD_TRACKER -- requirements
Module: axi_ostd_tracker

Interface
REQ-001 SHALL have parameter IDW, default 4: AXI transaction ID width.
REQ-002 SHALL have parameter RW, default 2: route-tag width (originating port index).
REQ-003 SHALL have parameter DP, default 8: outstanding-entry depth; DP >= 2.
REQ-004 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port i_alloc_valid, input, 1: request issued, record entry.
REQ-007 SHALL have port o_alloc_ready, output, 1: entry can be accepted.
REQ-008 SHALL have port i_alloc_id, input, IDW: ID of issued request.
REQ-009 SHALL have port i_alloc_route, input, RW: route tag of issued request.
REQ-010 SHALL have port i_rsp_valid, input, 1: response beat present.
REQ-011 SHALL have port i_rsp_ready, input, 1: response beat accepted downstream.
REQ-012 SHALL have port i_rsp_id, input, IDW: response ID.
REQ-013 SHALL have port i_rsp_last, input, 1: final beat of response.
REQ-014 SHALL have port o_rsp_hit, output, 1: a valid entry matches i_rsp_id.
REQ-015 SHALL have port o_rsp_route, output, RW: route tag of the oldest matching entry.
REQ-016 SHALL have port o_rsp_err, output, 1: registered pulse, accepted beat had no match.
REQ-017 SHALL have port o_count, output, $clog2(DP+1): number of valid entries.
REQ-018 SHALL have ports o_full and o_empty, output, 1 each: count == DP / count == 0.

Function
REQ-019 Table SHALL be compacted: valid entries occupy indices 0..count-1; index 0 is oldest.
REQ-020 o_alloc_ready SHALL equal ~o_full (from registered count, no same-cycle free bypass).
REQ-021 Alloc SHALL occur when i_alloc_valid && o_alloc_ready; the entry is written at index count.
REQ-022 Lookup SHALL be combinational, zero latency: compare i_rsp_id against all valid entries.
REQ-023 o_rsp_hit SHALL be high when i_rsp_valid and at least one valid entry ID matches; otherwise low.
REQ-024 o_rsp_route SHALL come from the lowest-index match (same-ID responses return in issue order); 0 when no hit.
REQ-025 Free SHALL occur when i_rsp_valid && i_rsp_ready && i_rsp_last && o_rsp_hit; the matched entry k is removed.
REQ-026 On free, entries k+1..count-1 SHALL shift down one index; count decrements.
REQ-027 Non-last accepted beats SHALL leave the table unchanged.
REQ-028 Simultaneous alloc and free SHALL shift, then write the new entry at index count-1; count is unchanged.
REQ-029 An entry allocated in cycle N SHALL be visible to lookup from cycle N+1 (no write-to-lookup bypass).
REQ-030 If i_rsp_valid && i_rsp_ready && !o_rsp_hit, o_rsp_err SHALL assert for exactly one cycle on the following cycle.
REQ-031 Alloc while full SHALL be ignored; free while empty is impossible, because hit is low when empty.
REQ-032 Duplicate IDs SHALL be allowed and consume separate entries.

Reset
REQ-033 On i_rst, all valid bits, count, and o_rsp_err SHALL be cleared; o_empty=1, o_full=0, o_alloc_ready=1.
REQ-034 Reset mid-operation SHALL discard all outstanding entries with no error pulse.
REQ-035 Entry ID and route storage need no reset; outputs SHALL be masked by the valid bits.

Structure
REQ-036 Entry struct {id, route} and default widths SHALL live in the shared axi package.
REQ-037 Oldest-match priority encoder SHALL be a sub-module, axi_prio_enc (DP-bit one-hot-first + index).
REQ-038 Valid bits SHALL be a thermometer vector (bit i == i < count); o_count is derived from it or kept consistent with it.

Verification
REQ-039 Reset, then alloc IDs 3,5,3 with routes 1,2,0 -> count=3; rsp id 3 last -> hit, route=1, count=2, remaining order {5/2, 3/0}.
REQ-040 Fill 8 entries -> o_full=1, o_alloc_ready=0; alloc during full is dropped; free entry 4 -> entries 5..7 shift to 4..6.
REQ-041 Same-cycle alloc id 7 and free of index 0 when count=4 -> count stays 4, id 7 at index 3.
REQ-042 Rsp id 9 accepted with no match -> o_rsp_hit=0, o_rsp_err=1 next cycle only; table unchanged.
REQ-043 Multi-beat rsp id 5 (3 beats, last on beat 3) -> hit on all beats, free only after beat 3; ready low on beat 3 delays the free.
REQ-044 Alloc id 2 in cycle N with rsp id 2 in the same cycle -> miss in N; hit in N+1; i_rst mid-stream -> empty, count=0.
